// File: rtl/rom_rd_port.sv
// Read-request front end for the banked synchronous ROM: accepts requests,
// steers the bank mux and buffers returned words in a 2-entry output FIFO.
module rom_rd_port #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_addr,
    output logic [AW-2:0]    bank_addr,
    output logic             bank_en,
    output logic             sel,
    input  logic [WIDTH-1:0] mux_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      rd_cnt,
    output logic             busy
);

    logic             s1_valid_q;
    logic             sel_q;
    logic             sel_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             wr_ptr_q;
    logic             wr_ptr_d;
    logic             rd_ptr_q;
    logic             rd_ptr_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [15:0]      rd_cnt_q;
    logic [15:0]      rd_cnt_d;
    logic             push;
    logic             pop;
    logic [2:0]       occ;

    assign push      = s1_valid_q;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;

    // Space is reserved at accept time, so the in-flight stage-1 word
    // counts as occupied; a pop in this cycle frees a slot immediately.
    assign occ = {1'b0, count_q} + {2'b00, s1_valid_q} - {2'b00, pop};

    assign in_ready  = !rst && (occ < 3'd2);
    assign bank_en   = in_valid && in_ready;
    assign bank_addr = in_addr[AW-2:0];

    assign sel      = sel_q;
    assign out_data = mem_q[rd_ptr_q];
    assign rd_cnt   = rd_cnt_q;
    assign busy     = s1_valid_q || (count_q != 2'd0);

    always_comb begin
        sel_d    = sel_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_cnt_d = rd_cnt_q;
        if (bank_en) begin
            sel_d = in_addr[AW-1];
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            sel_q      <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            rd_cnt_q   <= 16'd0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            s1_valid_q <= bank_en;
            sel_q      <= sel_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= mux_q;
            end
        end
    end

    // The accept-time reservation must make a push into a full buffer impossible.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == 2'd2))
    );

endmodule

// File: tb/tb_rom_rd_port.sv
// Bench for rom_rd_port: ROM/mux environment, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_rom_rd_port;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_addr;
    logic [4:0] bank_addr;
    logic       bank_en;
    logic       sel;
    logic [7:0] mux_q;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [15:0] rd_cnt;
    logic       busy;

    rom_rd_port #(.WIDTH(8), .AW(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .bank_addr (bank_addr),
        .bank_en   (bank_en),
        .sel       (sel),
        .mux_q     (mux_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rd_cnt    (rd_cnt),
        .busy      (busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_stall = 0;
    int cyc = 0;

    logic [7:0] b0 [32];
    logic [7:0] b1 [32];
    logic [4:0] rom_a = 5'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: two synchronous ROM banks and the 2:1 mux.
    always @(posedge clk) if (bank_en) rom_a <= bank_addr;
    assign mux_q = sel ? b1[rom_a] : b0[rom_a];

    function automatic logic [7:0] rom(input logic [5:0] a);
        return a[5] ? b1[a[4:0]] : b0[a[4:0]];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: words in flight and words buffered, as queues.
    logic [7:0] m_s1 [$];
    logic [7:0] m_fifo [$];
    logic [15:0] m_cnt = 16'd0;
    logic m_sel = 1'b0;
    logic [7:0] got [$];
    int got_cyc [$];

    always @(negedge clk) begin
        logic ev;
        logic pp;
        logic er;
        if (rst) begin
            m_s1.delete();
            m_fifo.delete();
            m_cnt = 16'd0;
            m_sel = 1'b0;
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_bank_en", 32'(bank_en), 0);
            chk("rst_rd_cnt", 32'(rd_cnt), 0);
        end else begin
            ev = (m_fifo.size() != 0);
            pp = ev && out_ready;
            er = (m_fifo.size() + m_s1.size() - (pp ? 1 : 0)) < 2;
            chk("m_out_valid", 32'(out_valid), 32'(ev));
            if (ev) chk("m_out_data", 32'(out_data), 32'(m_fifo[0]));
            chk("m_busy", 32'(busy), 32'(ev || m_s1.size() != 0));
            chk("m_in_ready", 32'(in_ready), 32'(er));
            chk("m_bank_en", 32'(bank_en), 32'(in_valid && er));
            chk("m_bank_addr", 32'(bank_addr), 32'(in_addr[4:0]));
            chk("m_sel", 32'(sel), 32'(m_sel));
            chk("m_rd_cnt", 32'(rd_cnt), 32'(m_cnt));
            if (pp) begin
                got.push_back(out_data);
                got_cyc.push_back(cyc);
                void'(m_fifo.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (m_s1.size() != 0) m_fifo.push_back(m_s1.pop_front());
            if (in_valid && er) begin
                m_s1.push_back(rom(in_addr));
                m_sel = in_addr[5];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [5:0] a);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_addr = a;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n_stall++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("req_accept", 32'(ok), 1);
    endtask

    logic [7:0] exp_s [8] = '{8'h10, 8'h80, 8'h11, 8'h81,
                              8'h12, 8'h82, 8'h13, 8'h83};
    logic [5:0] bp_a [4] = '{6'h07, 6'h27, 6'h08, 6'h28};
    logic [7:0] bp_d [4] = '{8'h17, 8'h87, 8'h18, 8'h88};

    initial begin
        int acc;
        for (int i = 0; i < 32; i++) begin
            b0[i] = 8'h10 + 8'(i);
            b1[i] = 8'h80 + 8'(i);
        end
        b1[5] = 8'hA5;
        rst = 1'b1;
        in_valid = 1'b0;
        in_addr = 6'd0;
        out_ready = 1'b0;
        tick(2);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_sel", 32'(sel), 0);
        rst = 1'b0;
        tick(1);

        // Single read from bank 1, word 5.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_addr = 6'h25;
        #1;
        chk("single_bank_en", 32'(bank_en), 1);
        chk("single_bank_addr", 32'(bank_addr), 32'h05);
        tick(1);
        in_valid = 1'b0;
        chk("single_sel", 32'(sel), 1);
        chk("single_lat_valid0", 32'(out_valid), 0);
        tick(1);
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data", 32'(out_data), 32'hA5);
        tick(1);
        chk("single_rd_cnt", 32'(rd_cnt), 1);
        chk("single_drained", 32'(out_valid), 0);

        // Streaming, alternating banks.
        got.delete();
        got_cyc.delete();
        n_stall = 0;
        for (int i = 0; i < 8; i++) req({i[0], 2'b00, 3'(i >> 1)});
        tick(3);
        chk("stream_count", 32'(got.size()), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("stream_data", 32'(got[i]), 32'(exp_s[i]));
        if (got.size() == 8)
            chk("stream_consecutive", 32'(got_cyc[7] - got_cyc[0]), 7);
        chk("stream_no_stall", 32'(n_stall), 0);
        chk("stream_rd_cnt", 32'(rd_cnt), 9);

        // Backpressure.
        got.delete();
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        in_addr = bp_a[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            in_addr = bp_a[acc];
        end
        chk("bp_accepts", 32'(acc), 2);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_head", 32'(out_data), 32'h17);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_same_cycle", 32'(in_ready), 1);
        tick(1);
        in_valid = 1'b0;
        req(bp_a[3]);
        tick(4);
        chk("bp_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("bp_order", 32'(got[i]), 32'(bp_d[i]));

        // Push and pop on the same edge with one word buffered.
        got.delete();
        out_ready = 1'b0;
        req(6'h0A);
        req(6'h2A);
        out_ready = 1'b1;
        tick(1);
        chk("pp_valid", 32'(out_valid), 1);
        chk("pp_data", 32'(out_data), 32'h8A);
        tick(1);
        chk("pp_empty", 32'(out_valid), 0);
        chk("pp_count", 32'(got.size()), 2);
        if (got.size() == 2) begin
            chk("pp_first", 32'(got[0]), 32'h1A);
            chk("pp_second", 32'(got[1]), 32'h8A);
        end

        // Asynchronous reset with words in flight.
        got.delete();
        out_ready = 1'b0;
        req(6'h02);
        req(6'h22);
        in_valid = 1'b1;
        in_addr = 6'h33;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_bank_en", 32'(bank_en), 0);
        chk("arst_rd_cnt", 32'(rd_cnt), 0);
        out_ready = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        in_valid = 1'b0;
        chk("arst_lat_valid0", 32'(out_valid), 0);
        tick(1);
        chk("arst_valid", 32'(out_valid), 1);
        chk("arst_data", 32'(out_data), 32'h93);
        tick(1);
        chk("arst_rd_cnt1", 32'(rd_cnt), 1);
        chk("arst_no_stale", 32'(got.size()), 1);

        // rd_cnt wrap.
        got.delete();
        for (int i = 0; i < 65534; i++) req(6'(i));
        tick(3);
        chk("wrap_max", 32'(rd_cnt), 32'hFFFF);
        got.delete();
        req(6'h11);
        tick(3);
        chk("wrap_zero", 32'(rd_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
